// File: rtl/usr_shift_ctrl.sv
// Controller sequencing a 4-bit universal shift register for serial tx/rx.
// Optional parity cycle enabled by defining USR_CTRL_PARITY_EN.
module usr_shift_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_op,
  input  logic       cmd_dir,
  input  logic [3:0] cmd_data,
  input  logic       rx_bit,
  output logic       tx_bit,
  output logic       tx_en,
  output logic [1:0] usr_mode,
  output logic [3:0] usr_data_in,
  output logic       usr_serial_in,
  input  logic [3:0] usr_data_out,
  output logic       rsp_valid,
  output logic [3:0] rsp_data,
  output logic       rsp_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_PARITY,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       op_q, op_d;
  logic       dir_q, dir_d;
  logic [3:0] data_q, data_d;
`ifdef USR_CTRL_PARITY_EN
  logic       par_q, par_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      op_q    <= 1'b0;
      dir_q   <= 1'b0;
      data_q  <= 4'd0;
`ifdef USR_CTRL_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
`ifdef USR_CTRL_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    dir_d         = dir_q;
    data_d        = data_q;
`ifdef USR_CTRL_PARITY_EN
    par_d         = par_q;
`endif
    cmd_ready     = 1'b0;
    tx_bit        = 1'b1;
    tx_en         = 1'b0;
    usr_mode      = 2'b00;
    usr_data_in   = 4'd0;
    usr_serial_in = 1'b0;
    rsp_valid     = 1'b0;
    rsp_data      = 4'd0;
    rsp_err       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = cmd_op;
          dir_d   = cmd_dir;
          data_d  = cmd_data;
          cnt_d   = 2'd0;
          state_d = cmd_op ? S_SHIFT : S_LOAD;
        end
      end
      S_LOAD: begin
        usr_mode    = 2'b11;
        usr_data_in = data_q;
        state_d     = S_SHIFT;
      end
      S_SHIFT: begin
        usr_mode = dir_q ? 2'b10 : 2'b01;
        cnt_d    = cnt_q + 2'd1;
        if (!op_q) begin
          tx_en  = 1'b1;
          tx_bit = dir_q ? usr_data_out[3] : usr_data_out[0];
        end else begin
          usr_serial_in = rx_bit;
        end
        if (cnt_q == 2'd3) begin
`ifdef USR_CTRL_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_DONE;
`endif
        end
      end
      S_PARITY: begin
`ifdef USR_CTRL_PARITY_EN
        // Even parity over the word as originally commanded
        if (!op_q) begin
          tx_en  = 1'b1;
          tx_bit = ^data_q;
        end else begin
          par_d = rx_bit;
        end
        state_d = S_DONE;
`else
        state_d = S_IDLE;
`endif
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        rsp_data  = usr_data_out;
`ifdef USR_CTRL_PARITY_EN
        rsp_err   = op_q & (par_q ^ (^usr_data_out));
`endif
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// Directed bench for usr_shift_ctrl paired with a behavioural
// 4-bit universal shift register.
module tb_usr_shift_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_op = 1'b0;
  logic       cmd_dir = 1'b0;
  logic [3:0] cmd_data = 4'd0;
  logic       rx_bit = 1'b0;
  logic       tx_bit;
  logic       tx_en;
  logic [1:0] usr_mode;
  logic [3:0] usr_data_in;
  logic       usr_serial_in;
  logic [3:0] usr_data_out;
  logic       rsp_valid;
  logic [3:0] rsp_data;
  logic       rsp_err;

  logic [3:0] sr = 4'd0;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  usr_shift_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dir(cmd_dir), .cmd_data(cmd_data),
    .rx_bit(rx_bit), .tx_bit(tx_bit), .tx_en(tx_en),
    .usr_mode(usr_mode), .usr_data_in(usr_data_in),
    .usr_serial_in(usr_serial_in), .usr_data_out(usr_data_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  // Behavioural universal shift register
  always @(posedge clk) begin
    case (usr_mode)
      2'b11: sr <= usr_data_in;
      2'b01: sr <= {usr_serial_in, sr[3:1]};
      2'b10: sr <= {sr[2:0], usr_serial_in};
      default: ;
    endcase
  end
  assign usr_data_out = sr;

  task automatic test_reset;
    @(negedge clk); #1;
    n_tests++;
    if ({cmd_ready, tx_bit, tx_en, usr_mode, usr_data_in,
         usr_serial_in, rsp_valid, rsp_data, rsp_err}
        !== {1'b1, 1'b1, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b tx=%b en=%b mode=%b din=%b si=%b rv=%b rd=%b re=%b required 1 1 0 00 0000 0 0 0000 0",
               cmd_ready, tx_bit, tx_en, usr_mode, usr_data_in,
               usr_serial_in, rsp_valid, rsp_data, rsp_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_tx(input logic dir, input logic [3:0] data,
                         input logic [3:0] seq, input logic [1:0] smode,
                         input logic par);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_dir = dir; cmd_data = data;
    #1;
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL tx_accept: cmd_ready=%b required 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    n_tests++;
    if (usr_mode !== 2'b11 || usr_data_in !== data || tx_en !== 1'b0
        || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_load: mode=%b din=%b en=%b rdy=%b required 11 %b 0 0",
               usr_mode, usr_data_in, tx_en, cmd_ready, data);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_tests++;
      if (usr_mode !== smode || tx_en !== 1'b1 || tx_bit !== seq[i]
          || usr_serial_in !== 1'b0 || rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL tx_shift%0d: mode=%b en=%b bit=%b si=%b rv=%b required %b 1 %b 0 0",
                 i, usr_mode, tx_en, tx_bit, usr_serial_in, rsp_valid,
                 smode, seq[i]);
      end
    end
`ifdef USR_CTRL_PARITY_EN
    @(negedge clk); #1;
    n_tests++;
    if (usr_mode !== 2'b00 || tx_en !== 1'b1 || tx_bit !== par
        || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_parity: mode=%b en=%b bit=%b rv=%b required 00 1 %b 0",
               usr_mode, tx_en, tx_bit, rsp_valid, par);
    end
`else
    if (par === 1'bx) $display("note: parity argument unknown");
`endif
    @(negedge clk); #1;
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_data !== 4'b0000 || rsp_err !== 1'b0
        || usr_mode !== 2'b00 || tx_en !== 1'b0 || tx_bit !== 1'b1) begin
      n_fail++;
      $display("FAIL tx_done: rv=%b rd=%b re=%b mode=%b en=%b bit=%b required 1 0000 0 00 0 1",
               rsp_valid, rsp_data, rsp_err, usr_mode, tx_en, tx_bit);
    end
    @(negedge clk); #1;
    n_tests++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL tx_idle: rv=%b rdy=%b required 0 1",
               rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_rx(input logic dir, input logic [3:0] seq,
                         input logic [1:0] smode, input logic par,
                         input logic [3:0] exp_data, input logic exp_err);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_dir = dir; cmd_data = 4'hF;
    #1;
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rx_accept: cmd_ready=%b required 1", cmd_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      rx_bit = seq[i];
      #1;
      n_tests++;
      if (usr_mode !== smode || usr_serial_in !== seq[i] || tx_en !== 1'b0
          || tx_bit !== 1'b1 || usr_data_in !== 4'd0
          || rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rx_shift%0d: mode=%b si=%b en=%b bit=%b din=%b rv=%b required %b %b 0 1 0000 0",
                 i, usr_mode, usr_serial_in, tx_en, tx_bit, usr_data_in,
                 rsp_valid, smode, seq[i]);
      end
    end
`ifdef USR_CTRL_PARITY_EN
    @(negedge clk);
    rx_bit = par;
    #1;
    n_tests++;
    if (usr_mode !== 2'b00 || tx_en !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_parity: mode=%b en=%b rv=%b required 00 0 0",
               usr_mode, tx_en, rsp_valid);
    end
`endif
    @(negedge clk);
    rx_bit = 1'b0;
    #1;
    n_tests++;
`ifdef USR_CTRL_PARITY_EN
    if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_err !== exp_err
        || usr_mode !== 2'b00) begin
      n_fail++;
      $display("FAIL rx_done: rv=%b rd=%b re=%b mode=%b required 1 %b %b 00",
               rsp_valid, rsp_data, rsp_err, usr_mode, exp_data, exp_err);
    end
`else
    if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_err !== 1'b0
        || usr_mode !== 2'b00) begin
      n_fail++;
      $display("FAIL rx_done: rv=%b rd=%b re=%b mode=%b required 1 %b 0 00 (par %b err %b unused)",
               rsp_valid, rsp_data, rsp_err, usr_mode, exp_data, par, exp_err);
    end
`endif
    @(negedge clk); #1;
    n_tests++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rx_idle: rv=%b rdy=%b required 0 1",
               rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset_mid;
    int rsp_cnt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_dir = 1'b0;
    rx_bit = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_tests++;
    if (cmd_ready !== 1'b1 || usr_mode !== 2'b00 || rsp_valid !== 1'b0
        || usr_serial_in !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: rdy=%b mode=%b rv=%b si=%b required 1 00 0 0",
               cmd_ready, usr_mode, rsp_valid, usr_serial_in);
    end
    @(negedge clk);
    rst = 1'b0;
    rx_bit = 1'b0;
    #1;
    n_tests++;
    if (cmd_ready !== 1'b1 || usr_mode !== 2'b00) begin
      n_fail++;
      $display("FAIL post_reset_idle: rdy=%b mode=%b required 1 00",
               cmd_ready, usr_mode);
    end
    rsp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (rsp_valid === 1'b1) rsp_cnt++;
    end
    n_tests++;
    if (rsp_cnt != 0) begin
      n_fail++;
      $display("FAIL post_reset_rsp: rsp pulses=%0d required 0", rsp_cnt);
    end
  endtask

  task automatic test_back_to_back;
    int acc;
    int rsp;
    int both;
    acc = 0; rsp = 0; both = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 1'b1; cmd_dir = 1'b0;
      rx_bit = i[0];
      #1;
      if (cmd_ready === 1'b1) acc++;
      if (rsp_valid === 1'b1) rsp++;
      if (cmd_ready === 1'b1 && rsp_valid === 1'b1) both++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    if (rsp_valid === 1'b1) rsp++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (rsp_valid === 1'b1) rsp++;
    end
    n_tests++;
    if (acc != 4) begin
      n_fail++;
      $display("FAIL b2b_accepts: got %0d required 4", acc);
    end
    n_tests++;
    if (rsp != 4) begin
      n_fail++;
      $display("FAIL b2b_responses: got %0d required 4", rsp);
    end
    n_tests++;
    if (both != 0) begin
      n_fail++;
      $display("FAIL b2b_overlap: ready with rsp_valid %0d times required 0",
               both);
    end
  endtask

  initial begin
    test_reset();
    test_tx(1'b0, 4'b1010, 4'b1010, 2'b01, 1'b0);
    test_tx(1'b1, 4'b1010, 4'b0101, 2'b10, 1'b0);
    test_tx(1'b0, 4'b1011, 4'b1011, 2'b01, 1'b1);
    test_rx(1'b0, 4'b1101, 2'b01, 1'b1, 4'b1101, 1'b0);
    test_rx(1'b0, 4'b1101, 2'b01, 1'b0, 4'b1101, 1'b1);
    test_rx(1'b1, 4'b1101, 2'b10, 1'b1, 4'b1011, 1'b0);
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
